eh2_posit_round_enc: RTL and testbench

- Pipelined posit rounding and encoding stage. Sits directly downstream of the posit multiplier.
- Takes the unpacked product: sign, signed regime k, exponent, and fraction with guard/round/sticky bits. Produces a packed POSIT_LEN-bit posit.
- Handles round-to-nearest-even, regime saturation, zero/NaR and two's-complement negation.
- Two register stages with a valid/ready handshake, so it can be stalled by the register-file writeback arbiter.

---
 rtl/eh2_posit_round_enc.sv | 137 +++++++++++++
 tb/tb_eh2_posit_round_enc.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/eh2_posit_round_enc.sv
// Posit rounding/encoding stage: builds the regime/exponent/fraction string from
// the unpacked product, rounds to nearest even, clamps and packs with sign.
module eh2_posit_round_enc #(
    parameter int POSIT_LEN  = 16,
    parameter int ES         = 2,
    parameter int REGIME_BW  = $clog2(POSIT_LEN),
    parameter int FRAC_W_GRS = POSIT_LEN - ES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sgn,
    input  logic [REGIME_BW-1:0]  in_reg,
    input  logic [ES-1:0]         in_exp,
    input  logic [FRAC_W_GRS-1:0] in_fra,
    input  logic                  in_ovf,
    input  logic                  in_unf,
    input  logic                  in_zero,
    input  logic                  in_nar,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [POSIT_LEN-1:0]  out_posit
);

    localparam int MW   = POSIT_LEN - 1;
    localparam int SW   = 2 * POSIT_LEN;
    localparam int PAD  = SW - 2 - ES - FRAC_W_GRS;
    localparam int KMAX = POSIT_LEN - 2;
    localparam logic [MW-1:0] MAXMAG = '1;
    localparam logic [MW-1:0] MINMAG = MW'(1);

    logic                 w_s2_adv;
    logic                 w_s1_adv;
    logic signed [31:0]   w_k;
    logic                 w_kneg;
    logic [REGIME_BW-1:0] w_shamt;
    logic signed [SW-1:0] w_seed;
    logic signed [SW-1:0] w_str;
    logic                 w_kovf;
    logic                 w_kunf;

    logic                 r1_valid;
    logic [MW-1:0]        r1_m;
    logic                 r1_rb;
    logic                 r1_st;
    logic                 r1_sgn;
    logic                 r1_nar;
    logic                 r1_zero;
    logic                 r1_ovf;
    logic                 r1_unf;

    logic                 w_inc;
    logic [MW:0]          w_mr;
    logic [MW-1:0]        w_mag;
    logic [POSIT_LEN-1:0] w_posit;

    logic                 r2_valid;
    logic [POSIT_LEN-1:0] r2_posit;

    assign w_s2_adv  = !r2_valid || out_ready;
    assign w_s1_adv  = !r1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r2_valid;
    assign out_posit = r2_posit;

    // Regime run is made by arithmetic right shift of a seed whose top bit is the
    // run polarity: k>=0 shifts by k, k<0 shifts by -k-1 (= ~k).
    always_comb begin
        w_k     = {{(32-REGIME_BW){in_reg[REGIME_BW-1]}}, in_reg};
        w_kneg  = in_reg[REGIME_BW-1];
        w_shamt = w_kneg ? ~in_reg : in_reg;
        w_seed  = {(w_kneg ? 2'b01 : 2'b10), in_exp, in_fra, {PAD{1'b0}}};
        w_str   = w_seed >>> w_shamt;
        w_kovf  = w_k > KMAX;
        w_kunf  = w_k < -KMAX;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_m     <= '0;
            r1_rb    <= 1'b0;
            r1_st    <= 1'b0;
            r1_sgn   <= 1'b0;
            r1_nar   <= 1'b0;
            r1_zero  <= 1'b0;
            r1_ovf   <= 1'b0;
            r1_unf   <= 1'b0;
        end else if (w_s1_adv) begin
            r1_valid <= in_valid;
            if (in_valid) begin
                r1_m    <= w_str[SW-1 -: MW];
                r1_rb   <= w_str[SW-POSIT_LEN];
                r1_st   <= |w_str[SW-POSIT_LEN-1:0];
                r1_sgn  <= in_sgn;
                r1_nar  <= in_nar;
                r1_zero <= in_zero;
                r1_ovf  <= in_ovf || w_kovf;
                r1_unf  <= in_unf || w_kunf;
            end
        end
    end

    always_comb begin
        w_inc = r1_rb && (r1_st || r1_m[0]);
        w_mr  = {1'b0, r1_m} + (MW+1)'(w_inc);
        if (w_mr[MW])
            w_mag = MAXMAG;
        else if (w_mr == '0 && (r1_rb || r1_st))
            w_mag = MINMAG;
        else
            w_mag = w_mr[MW-1:0];
        if (r1_ovf)
            w_mag = MAXMAG;
        else if (r1_unf)
            w_mag = MINMAG;

        w_posit = r1_sgn ? -{1'b0, w_mag} : {1'b0, w_mag};
        if (r1_nar)
            w_posit = {1'b1, {MW{1'b0}}};
        else if (r1_zero)
            w_posit = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_posit <= '0;
        end else if (w_s2_adv) begin
            r2_valid <= r1_valid;
            if (r1_valid)
                r2_posit <= w_posit;
        end
    end

endmodule

// File: tb/tb_eh2_posit_round_enc.sv
// Directed vector bench for eh2_posit_round_enc, plus back-pressure and reset sequences.
module tb_eh2_posit_round_enc;

    localparam int RBW = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sgn;
    logic [RBW-1:0] in_reg;
    logic [1:0]  in_exp;
    logic [13:0] in_fra;
    logic        in_ovf, in_unf, in_zero, in_nar;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_posit;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Wider regime port so the k=14/k=-15 saturation cases are representable.
    eh2_posit_round_enc #(
        .POSIT_LEN(16),
        .ES(2),
        .REGIME_BW(RBW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sgn(in_sgn),
        .in_reg(in_reg),
        .in_exp(in_exp),
        .in_fra(in_fra),
        .in_ovf(in_ovf),
        .in_unf(in_unf),
        .in_zero(in_zero),
        .in_nar(in_nar),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_posit(out_posit)
    );

    typedef struct {
        string       name;
        logic        sgn;
        logic [RBW-1:0] k;
        logic [1:0]  e;
        logic [13:0] f;
        logic [3:0]  flags;  // {ovf, unf, zero, nar}
        logic [15:0] exp_p;
    } vec_t;

    vec_t vecs[$];
    logic [15:0] got[$];

    function automatic vec_t mk(string n, logic s, logic [RBW-1:0] k, logic [1:0] e,
                                logic [13:0] f, logic [3:0] fl, logic [15:0] x);
        vec_t v;
        v.name = n; v.sgn = s; v.k = k; v.e = e; v.f = f; v.flags = fl; v.exp_p = x;
        return v;
    endfunction

    task automatic check(string n, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, req);
        end
    endtask

    task automatic drive(vec_t v);
        in_sgn  = v.sgn;
        in_reg  = v.k;
        in_exp  = v.e;
        in_fra  = v.f;
        {in_ovf, in_unf, in_zero, in_nar} = v.flags;
        in_valid = 1'b1;
    endtask

    task automatic run_vec(vec_t v);
        int n;
        drive(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            check({v.name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({v.name, "_latency"}, n, 1);
            check(v.name, out_posit, v.exp_p);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic acc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_sgn = 0; in_reg = '0; in_exp = '0; in_fra = '0;
        in_ovf = 0; in_unf = 0; in_zero = 0; in_nar = 0;

        vecs.push_back(mk("k0_base",     0, 5'd0,  2'd0, 14'h0000, 4'b0000, 16'h4000));
        vecs.push_back(mk("k0_e1",       0, 5'd0,  2'd1, 14'h0800, 4'b0000, 16'h4900));
        vecs.push_back(mk("k0_e1_neg",   1, 5'd0,  2'd1, 14'h0800, 4'b0000, 16'hB700));
        vecs.push_back(mk("tie_carry",   0, 5'd0,  2'd0, 14'h3FFC, 4'b0000, 16'h4800));
        vecs.push_back(mk("tie_even",    0, 5'd0,  2'd0, 14'h3FF4, 4'b0000, 16'h47FE));
        vecs.push_back(mk("round_up",    0, 5'd0,  2'd0, 14'h0006, 4'b0000, 16'h4001));
        vecs.push_back(mk("round_neg",   1, 5'd0,  2'd0, 14'h0006, 4'b0000, 16'hBFFF));
        vecs.push_back(mk("ovf_pos",     0, 5'd0,  2'd0, 14'h0000, 4'b1000, 16'h7FFF));
        vecs.push_back(mk("ovf_neg",     1, 5'd0,  2'd0, 14'h0000, 4'b1000, 16'h8001));
        vecs.push_back(mk("unf_pos",     0, 5'd0,  2'd0, 14'h0000, 4'b0100, 16'h0001));
        vecs.push_back(mk("unf_neg",     1, 5'd0,  2'd0, 14'h0000, 4'b0100, 16'hFFFF));
        vecs.push_back(mk("ovf_unf",     0, 5'd0,  2'd0, 14'h0000, 4'b1100, 16'h7FFF));
        vecs.push_back(mk("zero",        1, 5'd3,  2'd1, 14'h1234, 4'b0010, 16'h0000));
        vecs.push_back(mk("nar_zero",    0, 5'd0,  2'd0, 14'h0000, 4'b0011, 16'h8000));
        vecs.push_back(mk("nar_ovf_neg", 1, 5'd0,  2'd0, 14'h0000, 4'b1001, 16'h8000));
        vecs.push_back(mk("k14",         0, 5'd14, 2'd0, 14'h0000, 4'b0000, 16'h7FFF));
        vecs.push_back(mk("k14_full",    0, 5'd14, 2'd3, 14'h3FFF, 4'b0000, 16'h7FFF));
        vecs.push_back(mk("k15_clamp",   0, 5'd15, 2'd0, 14'h0000, 4'b0000, 16'h7FFF));
        vecs.push_back(mk("km15_clamp",  0, 5'h11, 2'd0, 14'h0000, 4'b0000, 16'h0001));
        vecs.push_back(mk("km14_round",  0, 5'h12, 2'd3, 14'h0000, 4'b0000, 16'h0002));
        vecs.push_back(mk("k3_e2",       0, 5'd3,  2'd2, 14'h2000, 4'b0000, 16'h7A80));
        vecs.push_back(mk("km3_e3",      0, 5'h1D, 2'd3, 14'h0000, 4'b0000, 16'h0E00));
        vecs.push_back(mk("km1",         0, 5'h1F, 2'd0, 14'h0000, 4'b0000, 16'h2000));

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_posit", out_posit, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-pressure: two accepted, third stalled, output held.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(vecs[0]); #1;
        check("bp_ready_a", in_ready, 1);
        @(posedge clk); #1;
        drive(vecs[1]); #1;
        check("bp_ready_b", in_ready, 1);
        @(posedge clk); #1;
        drive(vecs[21]); #1;
        check("bp_ready_c", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_hold0", out_posit, 16'h4000);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("bp_hold", out_posit, 16'h4000);
            check("bp_stall", in_ready, 0);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid) got.push_back(out_posit);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        check("bp_count", got.size(), 3);
        if (got.size() == 3) begin
            check("bp_order0", got[0], 16'h4000);
            check("bp_order1", got[1], 16'h4900);
            check("bp_order2", got[2], 16'h0E00);
        end

        // Reset with both stages full drops everything.
        out_ready = 1'b0;
        drive(vecs[0]);
        @(posedge clk); #1;
        drive(vecs[1]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_pre_valid", out_valid, 1);
        check("rst_pre_stall", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_ready", in_ready, 1);
        out_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        check("rst_no_stale", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
